// File: rtl/mdu_pkg.sv
// Shared constants and types for the multiply/divide unit with HI/LO.
// Optional divider datapath is controlled by the MDU_DIV_EN macro.
package mdu_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = 32;
    localparam int CNT_W = $clog2(ITERS);

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

    // MULT and DIV treat operands as two's complement.
    function automatic logic is_signed_op(input op_e op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic is_div_op(input op_e op);
        return (op == DIV) || (op == DIVU);
    endfunction

    // Absolute value for signed ops, pass-through for unsigned ones.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring-division step datapath: 33-bit partial remainder and a
// quotient shift register that starts out holding the dividend.
// Produces one quotient bit per step; instantiated only under MDU_DIV_EN.
module mdu_div_core
    import mdu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // Shift the next dividend bit into the remainder and try subtracting.
    always_comb begin
        shifted = {prem, quo[WIDTH-1]};
        trial   = shifted - {2'b00, dvs};
    end

    // Keep the difference when it is non-negative, otherwise restore.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prem <= '0;
            quo  <= '0;
            dvs  <= '0;
        end else if (load) begin
            prem <= '0;
            quo  <= dividend;
            dvs  <= divisor;
        end else if (step) begin
            if (!trial[WIDTH+1]) begin
                prem <= trial[WIDTH:0];
                quo  <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                prem <= shifted[WIDTH:0];
                quo  <= {quo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo;
    assign remainder = prem[WIDTH-1:0];

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// IDLE -> CALC (32 iterations) -> FIX (sign fix, HI/LO write, done pulse).
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU run the same
// 33 cycles, pulse done and leave HI/LO untouched.
module mdu_hilo
    import mdu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               iterate;
    logic               in_signed;

    op_e                op_q;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_fix;
    logic               div_zero_flag;

    // Next-state and per-cycle control decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
        state_nxt = state;
        accept    = 1'b0;
        iterate   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                iterate = 1'b1;
                if (cnt == CNT_W'(ITERS - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, iteration counter and the registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= iterate ? cnt + 1'b1 : cnt;
            busy        <= (state_nxt != IDLE);
            done        <= (state == FIX);
            div_by_zero <= (state == FIX) && is_div_op(op_q) && div_zero_flag;
        end
    end

    assign in_signed = is_signed_op(op_e'(op));

    // Radix-2 shift-add step: add |a| into the upper half when the current
    // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
        end
        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    end

    // Operand capture on accept and multiplier accumulation during CALC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= MULT;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            mag_a  <= '0;
            acc    <= '0;
        end else if (accept) begin
            op_q   <= op_e'(op);
            sign_a <= in_signed & a[WIDTH-1];
            sign_b <= in_signed & b[WIDTH-1];
            mag_a  <= magnitude(a, in_signed);
            acc    <= {{WIDTH{1'b0}}, magnitude(b, in_signed)};
        end else if (iterate) begin
            acc    <= {mul_sum, acc[WIDTH-1:1]};
        end
    end

`ifdef MDU_DIV_EN
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] a_orig;
    logic             b_zero;

    mdu_div_core u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .step      (iterate),
        .dividend  (magnitude(a, in_signed)),
        .divisor   (magnitude(b, in_signed)),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // Divide-by-zero is decided from the raw divisor at accept time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_zero <= 1'b0;
        end else if (accept) begin
            b_zero <= (b == '0);
        end
    end

    // Quotient sign follows a^b, remainder sign follows the dividend; the
    // original dividend is rebuilt from its magnitude for the b==0 case.
    always_comb begin
        quo_fix = (sign_a ^ sign_b) ? -quotient : quotient;
        rem_fix = sign_a ? -remainder : remainder;
        a_orig  = sign_a ? -mag_a : mag_a;
    end

    assign div_zero_flag = b_zero;
`else
    assign div_zero_flag = 1'b0;
`endif

    // HI/LO: results land only in FIX; MTHI/MTLO only in IDLE without start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            if (!is_div_op(op_q)) begin
                hi <= prod_fix[2*WIDTH-1:WIDTH];
                lo <= prod_fix[WIDTH-1:0];
            end
`ifdef MDU_DIV_EN
            else if (b_zero) begin
                hi <= a_orig;
                lo <= '1;
            end else begin
                hi <= rem_fix;
                lo <= quo_fix;
            end
`endif
        end else if (state == IDLE && !start) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

endmodule
